// File: rtl/keypad_entry_fsm_if.sv
// Keypad-side and result-side signals of keypad_entry_fsm bundled as one port.
// Ports: row (keypad rows in), col (column strobes out), key_valid/key_code (accepted key),
//        entry (live typed value), number/number_valid (committed value and its update pulse).
interface keypad_entry_fsm_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] entry;
    logic [31:0] number;
    logic        number_valid;

    // The keypad entry block drives the scan columns and all results.
    modport master (
        input  row,
        output col, key_valid, key_code, entry, number, number_valid
    );

    // The keypad and downstream consumers drive the rows and observe everything else.
    modport slave (
        output row,
        input  col, key_valid, key_code, entry, number, number_valid
    );
endinterface

// File: rtl/keypad_entry_fsm.sv
// Scans a 4x4 active-low keypad, debounces presses and builds a decimal entry into a 32-bit value.
// Latency: a key is accepted DEBOUNCE_SCANS full frames plus 1 cycle after its first frame.
// No backpressure: key_valid and number_valid are one-cycle pulses that cannot be stalled.
// Ports: clock, reset_n (synchronous, active-low), kp (keypad_entry_fsm_if.master).
module keypad_entry_fsm #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    keypad_entry_fsm_if.master    kp
);
    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

    state_t             state;
    logic [3:0]         row_meta, row_sync;
    logic [TICK_W-1:0]  tick;
    logic [1:0]         col_idx;
    logic [3:0]         col_q;
    logic [11:0]        frame_low;      // low-row bits of columns 0..2, index col*4 + row
    logic [3:0]         cand;
    logic [CNT_W-1:0]   press_cnt, rel_cnt;
    logic [3:0]         digit_cnt;
    logic               key_valid_q, number_valid_q;
    logic [3:0]         key_code_q;
    logic [31:0]        entry_q, number_q;

    function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;  4'b11_01: k = 4'hF;  4'b11_10: k = 4'hE;  default:  k = 4'hD;
        endcase
        return k;
    endfunction

    logic        sample, frame_end;
    logic [15:0] frame_all;
    logic [4:0]  n_low;
    logic [3:0]  hit;
    logic        key_hit;
    logic [3:0]  hit_code;
    logic        accept;
    logic [31:0] entry_digit;

    assign sample    = (tick == TICK_LAST);
    assign frame_end = sample && (col_idx == 2'd3);
    // Column 3 is evaluated straight from the synchronizer on its own sample cycle.
    assign frame_all = {~row_sync, frame_low};

    always_comb begin
        n_low = 5'd0;
        hit   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_all[i]) begin
                n_low = n_low + 5'd1;
                hit   = 4'(i);
            end
        end
    end

    // More than one low bit is a possible ghost and is treated like no key at all.
    assign key_hit  = (n_low == 5'd1);
    assign hit_code = key_of(hit[1:0], hit[3:2]);

    assign accept = frame_end && key_hit &&
                    (((state == IDLE) && (CNT_DONE == CNT_W'(1))) ||
                     ((state == CONFIRM) && (hit_code == cand) && (press_cnt + CNT_W'(1) == CNT_DONE)));

    // v*10 + d as shifts and adds; eight digits cannot exceed 32 bits.
    assign entry_digit = (entry_q << 3) + (entry_q << 1) + {28'd0, hit_code};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            row_meta       <= 4'hF;
            row_sync       <= 4'hF;
            tick           <= '0;
            col_idx        <= 2'd0;
            col_q          <= 4'b1110;
            frame_low      <= 12'd0;
            cand           <= 4'd0;
            press_cnt      <= '0;
            rel_cnt        <= '0;
            digit_cnt      <= 4'd0;
            key_valid_q    <= 1'b0;
            number_valid_q <= 1'b0;
            key_code_q     <= 4'd0;
            entry_q        <= 32'd0;
            number_q       <= 32'd0;
        end else begin
            key_valid_q    <= 1'b0;
            number_valid_q <= 1'b0;
            row_meta       <= kp.row;
            row_sync       <= row_meta;

            if (sample) begin
                tick    <= '0;
                col_idx <= col_idx + 2'd1;
                col_q   <= {col_q[2:0], col_q[3]};
                case (col_idx)
                    2'd0:    frame_low[3:0]  <= ~row_sync;
                    2'd1:    frame_low[7:4]  <= ~row_sync;
                    2'd2:    frame_low[11:8] <= ~row_sync;
                    default: ;
                endcase
            end else begin
                tick <= tick + TICK_W'(1);
            end

            if (frame_end) begin
                if (accept) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= hit_code;
                    state       <= HELD;
                    press_cnt   <= '0;
                    rel_cnt     <= '0;
                    if (hit_code <= 4'd9) begin
                        // Digits past the eighth are swallowed but still reported.
                        if (digit_cnt < 4'd8) begin
                            entry_q   <= entry_digit;
                            digit_cnt <= digit_cnt + 4'd1;
                        end
                    end else if (hit_code == 4'hA) begin
                        entry_q   <= 32'd0;
                        digit_cnt <= 4'd0;
                    end else if (hit_code == 4'hC) begin
                        number_q       <= entry_q;
                        number_valid_q <= 1'b1;
                        entry_q        <= 32'd0;
                        digit_cnt      <= 4'd0;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            if (key_hit) begin
                                cand      <= hit_code;
                                press_cnt <= CNT_W'(1);
                                state     <= CONFIRM;
                            end
                        end
                        CONFIRM: begin
                            if (!key_hit) begin
                                press_cnt <= '0;
                                state     <= IDLE;
                            end else if (hit_code != cand) begin
                                cand      <= hit_code;
                                press_cnt <= CNT_W'(1);
                            end else begin
                                press_cnt <= press_cnt + CNT_W'(1);
                            end
                        end
                        HELD: begin
                            if (key_hit) begin
                                rel_cnt <= '0;
                            end else if (rel_cnt + CNT_W'(1) == CNT_DONE) begin
                                rel_cnt <= '0;
                                state   <= IDLE;
                            end else begin
                                rel_cnt <= rel_cnt + CNT_W'(1);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign kp.col          = col_q;
    assign kp.key_valid    = key_valid_q;
    assign kp.key_code     = key_code_q;
    assign kp.entry        = entry_q;
    assign kp.number       = number_q;
    assign kp.number_valid = number_valid_q;
endmodule

// File: doc/keypad_entry_fsm.md
# keypad_entry_fsm

Scans a 4x4 matrix keypad (Digilent Pmod KYPD pinout), debounces presses, and assembles typed decimal digits into a 32-bit binary number. It is the input-side counterpart of the multiplexed seven-segment driver: that block strobes anodes outward at a 1 ms rate, and this block strobes keypad columns and reads rows back at the same rate. `entry` feeds the display's 32-bit number input for live echo. `number` and `number_valid` deliver the committed value to downstream logic.

## Interface
- `SCAN_TICKS`, default 100000: clock cycles each column stays driven (1 ms at 100 MHz).
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press, and consecutive empty scans required to accept a release.
- `clock`  in  1: single clock; all logic is on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `row`  in  4: keypad rows, active-low, externally pulled up.
- `col`  out  4: keypad columns, active-low, one-hot-low; `col[c]` is low while column c is scanned.
- `key_valid`  out  1: one-cycle pulse per accepted keypress.
- `key_code`  out  4: code of the last accepted key.
- `entry`  out  32: live binary value being typed.
- `number`  out  32: last committed value.
- `number_valid`  out  1: one-cycle pulse when `number` updates.

## Operation
- Keymap, listed as row r (index into `row`) by column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- `key_code` is the hex value of the key label.
- Scan frame: columns 0, 1, 2, 3 in turn, each for `SCAN_TICKS` cycles. `row` is sampled on the last cycle of each column slot.
- Frame result:
  - Exactly one low row bit across all four samples gives that key.
  - No low bits gives NONE.
  - Two or more low bits gives MULTI, which is treated as NONE (ghost rejection).
- States:
  - IDLE: a key result loads the candidate, sets count=1 and moves to CONFIRM.
  - CONFIRM: the same key increments count. A different key reloads the candidate with count=1. NONE returns to IDLE.
  - Accept: when count reaches `DEBOUNCE_SCANS`, pulse `key_valid`, load `key_code`, apply the key action, and move to HELD.
  - HELD: NONE results increment the release count; any key result clears it. At `DEBOUNCE_SCANS` go to IDLE.
  - With `DEBOUNCE_SCANS`=1, acceptance happens on the first frame.
- Key actions:
  - Digits 0-9: if digit_count<8, `entry` <= `entry`*10 + d and digit_count increments. Otherwise the digit is ignored, but `key_valid` still pulses.
  - The *10 is (v<<3)+(v<<1). The maximum value 99,999,999 fits in 32 bits, so there is no overflow.
  - A (clear): `entry`=0, digit_count=0.
  - C (enter): `number` <= `entry` and `number_valid` pulses. `entry` and digit_count clear in the same cycle.
  - B, D, E, F: no action beyond `key_valid`/`key_code`.
- Leading zeros count as digits; `entry` stays 0.
- A key held indefinitely produces exactly one `key_valid`; there is no auto-repeat.

## Timing
- Reset values:
  - `col`=4'b1110
  - `key_valid`=0, `number_valid`=0
  - `key_code`=0
  - `entry`=0, `number`=0
  - digit_count=0, state IDLE, all counters 0
- Frame length is 4*`SCAN_TICKS` cycles. Column changes occur on the cycle after each slot's sample cycle.
- The frame result is evaluated on the column-3 sample cycle, and state updates on that edge.
- `key_valid`, `number_valid`, `key_code`, `entry` and `number` all change on the first cycle after the accepting frame's last sample. Pulses last exactly 1 cycle.
- Press-to-`key_valid` latency: `DEBOUNCE_SCANS` full frames plus 1 cycle, measured from the first frame in which the key is seen.
- Reset asserted mid-scan, mid-CONFIRM or in HELD aborts everything on the next edge. A key still held after release of reset is debounced from scratch and yields one `key_valid`.
- `row` is treated as asynchronous and is passed through a 2-flop synchronizer before sampling.

## Test plan
Bench parameters: `SCAN_TICKS`=4, `DEBOUNCE_SCANS`=2, giving a 16-cycle frame.

1. Reset for 3 cycles with `row`=4'hF. Expect `col`=4'b1110, all outputs 0. Then `col` must cycle 1110, 1101, 1011, 0111, changing every 4 cycles.
2. Hold key 5 (row1 low while `col[1]` low) for 6 frames. Expect exactly one `key_valid`, with `key_code`=5 and `entry`=5, 2 frames + 1 cycle after the first full frame containing the press.
3. Press and release 1, 2, 3, then C. Expect `entry`=1, 12, 123. On C: `number`=123, one `number_valid` pulse, `entry`=0.
4. Type 9 nine times. Expect `entry`=99999999 after the 8th press; the 9th gives a `key_valid` pulse but `entry` is unchanged. Then press A: expect `entry`=0 while `number` is unchanged.
5. Present key 7 in alternating frames only: expect no `key_valid`. Hold 1 and 2 together: expect no `key_valid`.
6. Hold key 8. Assert `reset_n`=0 for 2 cycles during CONFIRM, then release reset with 8 still held. Expect exactly one `key_valid` (`key_code`=8) after 2 fresh frames.
